// File: rtl/pwm_dt_pkg.sv
// Shared state encoding and defaults for the complementary PWM dead-time output stage.
package pwm_dt_pkg;

  localparam int DT_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ON_P,
    ST_DT_TO_N,
    ST_ON_N,
    ST_DT_TO_P
  } dt_state_t;

  // Gate-drive pair {oc, ocn} presented while the FSM sits in a given state.
  function automatic logic [1:0] drive_of(input dt_state_t s);
    case (s)
      ST_ON_P: return 2'b10;
      ST_ON_N: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/pwm_dt_chan.sv
// One complementary output channel: reference edge detect, dead-time FSM and
// dead-time counter, with the gate drives registered from the next state.
module pwm_dt_chan
  import pwm_dt_pkg::*;
#(
  parameter int DT_WIDTH = DT_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_en,
  input  logic                i_ref,
  input  logic [DT_WIDTH-1:0] i_dtg,
  output logic                o_oc,
  output logic                o_ocn
);

  logic                r_ref_prev;
  dt_state_t           r_state;
  logic [DT_WIDTH-1:0] r_cnt;
  logic                r_oc;
  logic                r_ocn;

  logic                w_rise;
  logic                w_fall;
  logic                w_dt_zero;
  logic [DT_WIDTH-1:0] w_load;
  dt_state_t           w_state_next;
  logic [DT_WIDTH-1:0] w_cnt_next;

  assign w_rise    = i_ref & ~r_ref_prev;
  assign w_fall    = ~i_ref & r_ref_prev;
  assign w_dt_zero = (i_dtg == '0);
  // Entry edge counts as the first dead-time cycle, so load dtg-1.
  assign w_load    = i_dtg - DT_WIDTH'(1);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (!i_en) begin
      w_state_next = ST_IDLE;
      w_cnt_next   = '0;
    end else if (w_rise) begin
      if (w_dt_zero) begin
        w_state_next = ST_ON_P;
      end else begin
        w_state_next = ST_DT_TO_P;
        w_cnt_next   = w_load;
      end
    end else if (w_fall) begin
      if (w_dt_zero) begin
        w_state_next = ST_ON_N;
      end else begin
        w_state_next = ST_DT_TO_N;
        w_cnt_next   = w_load;
      end
    end else begin
      case (r_state)
        ST_IDLE: w_state_next = i_ref ? ST_ON_P : ST_ON_N;
        ST_DT_TO_P: begin
          if (r_cnt == '0) w_state_next = ST_ON_P;
          else             w_cnt_next   = r_cnt - DT_WIDTH'(1);
        end
        ST_DT_TO_N: begin
          if (r_cnt == '0) w_state_next = ST_ON_N;
          else             w_cnt_next   = r_cnt - DT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ref_prev <= 1'b0;
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_oc       <= 1'b0;
      r_ocn      <= 1'b0;
    end else begin
      r_ref_prev     <= i_ref;
      r_state        <= w_state_next;
      r_cnt          <= w_cnt_next;
      {r_oc, r_ocn}  <= drive_of(w_state_next);
    end
  end

  assign o_oc  = r_oc;
  assign o_ocn = r_ocn;

endmodule

// File: rtl/pwm_deadtime_out.sv
// Two-channel complementary PWM output stage with dead-time insertion.
// Define PWM_DT_BREAK_EN to compile in the break input and sticky brk_flag.
module pwm_deadtime_out
  import pwm_dt_pkg::*;
#(
  parameter int DT_WIDTH = DT_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pwm_ch1,
  input  logic                pwm_ch2,
  input  logic [DT_WIDTH-1:0] dtg,
  input  logic                moe,
  input  logic                break_in,
  input  logic                brk_clr,
  output logic                oc1,
  output logic                oc1n,
  output logic                oc2,
  output logic                oc2n,
  output logic                brk_flag
);

  logic [1:0] w_ref;
  logic [1:0] w_oc;
  logic [1:0] w_ocn;
  logic       w_en;

  assign w_ref = {pwm_ch2, pwm_ch1};

`ifdef PWM_DT_BREAK_EN
  logic r_brk_flag;

  // Break wins over clear; outputs stay parked until the flag is cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_brk_flag <= 1'b0;
    else if (break_in) r_brk_flag <= 1'b1;
    else if (brk_clr)  r_brk_flag <= 1'b0;
  end

  assign w_en     = moe & ~break_in & ~r_brk_flag;
  assign brk_flag = r_brk_flag;
`else
  logic w_unused_brk;

  assign w_unused_brk = break_in ^ brk_clr;
  assign w_en         = moe;
  assign brk_flag     = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      pwm_dt_chan #(
        .DT_WIDTH(DT_WIDTH)
      ) u_chan (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_en),
        .i_ref (w_ref[gi]),
        .i_dtg (dtg),
        .o_oc  (w_oc[gi]),
        .o_ocn (w_ocn[gi])
      );
    end
  endgenerate

  assign oc1  = w_oc[0];
  assign oc1n = w_ocn[0];
  assign oc2  = w_oc[1];
  assign oc2n = w_ocn[1];

endmodule

// File: tb/tb_pwm_deadtime_out.sv
// Scoreboard bench for pwm_deadtime_out: expected output vectors are queued per
// clock edge up front, and a monitor compares them on the falling edge.
module tb_pwm_deadtime_out;

  localparam int DTW = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           pwm_ch1 = 1'b0;
  logic           pwm_ch2 = 1'b0;
  logic [DTW-1:0] dtg = 8'd4;
  logic           moe = 1'b1;
  logic           break_in = 1'b0;
  logic           brk_clr = 1'b0;
  logic           oc1, oc1n, oc2, oc2n, brk_flag;

  // Vector layout {oc1, oc1n, oc2, oc2n, brk_flag}
  localparam logic [4:0] V_N_N  = 5'b01010;
  localparam logic [4:0] V_D_N  = 5'b00010;
  localparam logic [4:0] V_P_N  = 5'b10010;
  localparam logic [4:0] V_N_P  = 5'b01100;
  localparam logic [4:0] V_BRK  = 5'b00001;
  localparam logic [4:0] V_ZERO = 5'b00000;

  typedef struct {
    int         cyc;
    logic [4:0] vec;
    string      name;
  } chk_t;

  chk_t sb_q[$];
  chk_t imm_q[$];
  event ev_imm;
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   stim_done = 1'b0;

  pwm_deadtime_out #(.DT_WIDTH(DTW)) dut (
    .clk      (clk),
    .rst      (rst),
    .pwm_ch1  (pwm_ch1),
    .pwm_ch2  (pwm_ch2),
    .dtg      (dtg),
    .moe      (moe),
    .break_in (break_in),
    .brk_clr  (brk_clr),
    .oc1      (oc1),
    .oc1n     (oc1n),
    .oc2      (oc2),
    .oc2n     (oc2n),
    .brk_flag (brk_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst) edge_cnt <= edge_cnt + 1;

  task automatic exp_win(input int c0, input int c1, input logic [4:0] v, input string nm);
    chk_t e;
    for (int c = c0; c <= c1; c++) begin
      e.cyc = c; e.vec = v; e.name = nm;
      sb_q.push_back(e);
    end
  endtask

  task automatic exp_now(input logic [4:0] v, input string nm);
    chk_t e;
    e.cyc = -1; e.vec = v; e.name = nm;
    imm_q.push_back(e);
    -> ev_imm;
  endtask

  // Returns shortly after the falling edge that follows clock edge n.
  task automatic goto(input int n);
    while (edge_cnt < n) @(negedge clk);
    #1;
  endtask

  task automatic note(input string what);
    $display("edge %0d: %s", edge_cnt, what);
  endtask

  // Monitor: compares queued expectations against the DUT.
  initial begin : monitor
    chk_t       e;
    logic [4:0] act;
    forever begin
      @(negedge clk or ev_imm);
      #0;
      while (imm_q.size() > 0) begin
        e   = imm_q.pop_front();
        act = {oc1, oc1n, oc2, oc2n, brk_flag};
        n_checks++;
        if (act !== e.vec) begin
          n_fail++;
          $display("FAIL %s (no clock edge): got %b required %b", e.name, act, e.vec);
        end
      end
      if (!rst && !clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= edge_cnt) begin
          e   = sb_q.pop_front();
          act = {oc1, oc1n, oc2, oc2n, brk_flag};
          n_checks++;
          if (e.cyc < edge_cnt) begin
            n_fail++;
            $display("FAIL %s edge %0d: expectation not reached in time (now edge %0d)", e.name, e.cyc, edge_cnt);
          end else if (act !== e.vec) begin
            n_fail++;
            $display("FAIL %s edge %0d: got {oc1,oc1n,oc2,oc2n,brk_flag}=%b required %b",
                     e.name, e.cyc, act, e.vec);
          end
        end
        if (stim_done) begin
          if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL leftover: got %0d unchecked expectations required 0", sb_q.size());
          end
          $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
          $finish;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no completion by 100000 required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    // dtg=4 rise at 10 / fall at 50
    exp_win(1, 9, V_N_N, "dt4_before_rise");
    exp_win(10, 13, V_D_N, "dt4_dead_to_p");
    exp_win(14, 49, V_P_N, "dt4_on_p");
    exp_win(50, 53, V_D_N, "dt4_dead_to_n");
    exp_win(54, 61, V_N_N, "dt4_on_n");
    // dtg=0, ref2 toggles every 8 edges starting with a rise at 62
    for (int i = 0; i < 6; i++)
      exp_win(62 + 8 * i, 69 + 8 * i, (i % 2 == 0) ? V_N_P : V_N_N, "dt0_ch2");
    // dtg=6, 3-cycle ref1 pulse rising at 112 is swallowed
    exp_win(110, 111, V_N_N, "short_before");
    exp_win(112, 120, V_D_N, "short_swallowed");
    exp_win(121, 129, V_N_N, "short_after");
    // dtg=5 latched at 130, changed to 2 mid dead-time
    exp_win(130, 134, V_D_N, "dtg_latched_5");
    exp_win(135, 139, V_P_N, "dtg_on_p");
    exp_win(140, 141, V_D_N, "dtg_next_2");
    exp_win(142, 147, V_N_N, "dtg_on_n");
    exp_win(148, 149, V_D_N, "pre_break_dead");
`ifdef PWM_DT_BREAK_EN
    exp_win(150, 151, V_P_N, "pre_break_on_p");
    exp_win(152, 157, V_BRK, "break_held");
    exp_win(158, 158, V_ZERO, "break_cleared");
    exp_win(159, 162, V_P_N, "break_resume");
`else
    exp_win(150, 162, V_P_N, "break_ignored");
`endif
    // reset mid DT_TO_P
    exp_win(163, 165, V_N_N, "prerst_on_n");
    exp_win(166, 167, V_D_N, "prerst_dead");
    exp_win(168, 171, V_D_N, "postrst_dead");
    exp_win(172, 175, V_P_N, "postrst_on_p");

    #1 rst = 1'b1;
    #2 exp_now(V_ZERO, "reset_state");
    #19 rst = 1'b0;
    note("reset released, moe=1 dtg=4");

    goto(9);   pwm_ch1 = 1'b1; note("ref1 rise for edge 10");
    goto(49);  pwm_ch1 = 1'b0; note("ref1 fall for edge 50");
    goto(59);  dtg = 8'd0;     note("dtg=0");
    for (int i = 0; i < 6; i++) begin
      goto(61 + 8 * i);
      pwm_ch2 = (i % 2 == 0);
      note("ref2 toggle");
    end
    goto(109); dtg = 8'd6;     note("dtg=6");
    goto(111); pwm_ch1 = 1'b1; note("ref1 short pulse start");
    goto(114); pwm_ch1 = 1'b0; note("ref1 short pulse end");
    goto(125); dtg = 8'd5;     note("dtg=5");
    goto(129); pwm_ch1 = 1'b1; note("ref1 rise for edge 130");
    goto(132); dtg = 8'd2;     note("dtg=2 mid dead-time");
    goto(139); pwm_ch1 = 1'b0; note("ref1 fall for edge 140");
    goto(147); pwm_ch1 = 1'b1; note("ref1 rise for edge 148");
    goto(151); break_in = 1'b1; note("break pulse");
    goto(152); break_in = 1'b0;
    goto(154); break_in = 1'b1; brk_clr = 1'b1; note("clear while break high");
    goto(155); break_in = 1'b0; brk_clr = 1'b0;
    goto(157); brk_clr = 1'b1; note("clear with break low");
    goto(158); brk_clr = 1'b0;
    goto(162); pwm_ch1 = 1'b0; dtg = 8'd0; note("ref1 fall, dtg=0");
    goto(164); dtg = 8'd4;     note("dtg=4");
    goto(165); pwm_ch1 = 1'b1; note("ref1 rise for edge 166");
    goto(167); rst = 1'b1;
    #1 exp_now(V_ZERO, "async_reset");
    #1 rst = 1'b0;
    note("async reset pulse between edges");
    goto(176);
    stim_done = 1'b1;
  end

endmodule
